// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box table, GF(2^8) xtime, round-key type, key-bank constants.
// No logic of its own; functions are purely combinational when used.
// No flow control; consumers use these on any cycle.
package aes_pkg;

  typedef logic [127:0] round_key_t;

  localparam int         RK_COUNT  = 11;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box. Entry 0 is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: derives round key r from round key r-1 and rcon.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs at all times.
// Ports: prev_key (round key r-1, word 0 in [127:96]), rcon (round constant), next_key (round key r).
module aes_key_step (
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);
  import aes_pkg::*;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] w4, w5, w6, w7;

  assign {w0, w1, w2, w3} = prev_key;

  // RotWord moves byte 0 of w3 to the least significant position.
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

  assign w4 = w0 ^ sub ^ {rcon, 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/aes128_key_store.sv
// Iterative AES-128 key schedule feeding a decryptor: expands one round key per clock into an 11-entry bank.
// Latency: key_load sampled at edge E0 -> keys_valid/done after E10; rd_key is registered, one cycle after rd_idx.
// Backpressure: none; key_load is accepted every cycle and restarts expansion, abandoning any partial schedule.
// Ports: clk, rst (sync, active high), key_in/key_load (new cipher key), busy/keys_valid/done (status),
//        rd_idx/rd_key (indexed read of round keys 0..10, out-of-range indices read as zero).
module aes128_key_store #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  import aes_pkg::*;

  if (NR != 10) begin : g_nr_check
    $error("aes128_key_store supports only NR=10 (AES-128)");
  end

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [7:0]  rcon;
  round_key_t  slot [RK_COUNT];
  round_key_t  prev_key;
  round_key_t  next_key;
  logic [3:0]  prev_idx;

  // Guard the source index so an idle/ready counter value never selects past the bank.
  assign prev_idx = cnt - 4'd1;
  assign prev_key = (prev_idx < 4'(RK_COUNT)) ? slot[prev_idx] : '0;

  aes_key_step u_step (
    .prev_key (prev_key),
    .rcon     (rcon),
    .next_key (next_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rcon       <= 8'h00;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      rd_key     <= '0;
    end else begin
      done   <= 1'b0;
      rd_key <= (rd_idx < 4'(RK_COUNT)) ? slot[rd_idx] : '0;
      // A new key wins over an expansion in flight, from any state.
      if (key_load) begin
        state      <= EXPAND;
        cnt        <= 4'd1;
        rcon       <= RCON_INIT;
        busy       <= 1'b1;
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        cnt  <= cnt + 4'd1;
        rcon <= xtime(rcon);
        if (cnt == 4'(NR)) begin
          state      <= READY;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
          done       <= 1'b1;
        end
      end
    end
  end

  // Key bank carries no reset; its contents are qualified by keys_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (key_load) begin
        slot[0] <= key_in;
      end else if (state == EXPAND && cnt < 4'(RK_COUNT)) begin
        slot[cnt] <= next_key;
      end
    end
  end

endmodule

// File: tb/tb_aes128_key_store.sv
`timescale 1ns/1ps
module tb_aes128_key_store;

  logic         clk = 1'b0;
  logic         rst, key_load, busy, keys_valid, done;
  logic [127:0] key_in, rd_key;
  logic [3:0]   rd_idx;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sb [256];
  logic [127:0] ref_rk [11];

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  aes128_key_store #(.NR(10)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .busy(busy), .keys_valid(keys_valid), .done(done),
    .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (FIPS-197 word formulation) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [127:0] k);
    key_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Returns the number of edges until done is seen, or -1 when the budget runs out.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    rd_idx = idx;
    tick();
    val = rd_key;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; key_load = 1'b0; key_in = '0; rd_idx = 4'd0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL reset_keys_valid: got %b want 0", keys_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL reset_rd_key: got %h want 0", rd_key); end
    rst = 1'b0;
    rd_idx = 4'd3;
    tick(); tick();
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL idle_keys_valid: got %b want 0", keys_valid); end
  endtask

  task automatic test_fips_load();
    int cyc;
    logic [127:0] v;
    pulse_load(K_FIPS);
    vectors++; if (busy !== 1'b1 || keys_valid !== 1'b0) begin miscompares++; $display("FAIL fips_busy_after_load: got busy=%b kv=%b want busy=1 kv=0", busy, keys_valid); end
    wait_done(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL fips_done_latency: got %0d want 10", cyc); end
    vectors++; if (keys_valid !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL fips_status: got kv=%b busy=%b want kv=1 busy=0", keys_valid, busy); end
    read_rk(4'd1, v);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL fips_done_one_cycle: got %b want 0", done); end
    vectors++; if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin miscompares++; $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", v); end
    read_rk(4'd10, v);
    vectors++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin miscompares++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    read_rk(4'd0, v);
    vectors++; if (v !== K_FIPS) begin miscompares++; $display("FAIL fips_rk0: got %h want %h", v, K_FIPS); end
    ref_expand(K_FIPS);
    for (int r = 0; r < 11; r++) begin
      read_rk(4'(r), v);
      vectors++; if (v !== ref_rk[r]) begin miscompares++; $display("FAIL fips_model_rk%0d: got %h want %h", r, v, ref_rk[r]); end
    end
  endtask

  // Also checks that a read of slot 10 on the edge that writes it returns the old key.
  task automatic test_second_key();
    int cyc;
    logic [127:0] old10;
    ref_expand(K_FIPS);
    old10 = ref_rk[10];
    rd_idx = 4'd10;
    pulse_load(K_SEQ);
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL second_kv_drop: got %b want 0", keys_valid); end
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (keys_valid === 1'b1) begin cyc = c; break; end
    end
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL second_kv_latency: got %0d want 10", cyc); end
    vectors++; if (rd_key !== old10) begin miscompares++; $display("FAIL read_during_write: got %h want %h", rd_key, old10); end
    tick();
    vectors++; if (rd_key !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin miscompares++; $display("FAIL second_rk10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", rd_key); end
  endtask

  task automatic test_restart();
    int pulses, first;
    logic [127:0] v;
    pulse_load(K_FIPS);                // E0
    tick(); tick(); tick();            // E1..E3
    pulse_load(K_SEQ);                 // E4
    pulses = 0; first = -1;
    for (int c = 5; c <= 30; c++) begin
      tick();
      if (done === 1'b1) begin pulses++; if (first < 0) first = c; end
    end
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL restart_pulse_count: got %0d want 1", pulses); end
    vectors++; if (first != 14) begin miscompares++; $display("FAIL restart_done_edge: got E%0d want E14", first); end
    read_rk(4'd10, v);
    vectors++; if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin miscompares++; $display("FAIL restart_rk10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", v); end
  endtask

  task automatic test_reset_mid();
    int pulses, cyc;
    logic [127:0] v;
    pulse_load(K_SEQ);                 // E0
    tick(); tick(); tick(); tick();    // E1..E4
    rst = 1'b1;
    tick();                            // E5
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || keys_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_status: got busy=%b kv=%b want 0 0", busy, keys_valid); end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin tick(); if (done === 1'b1 || keys_valid === 1'b1) pulses++; end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL reset_mid_no_done: got %0d cycles with done/kv want 0", pulses); end
    pulse_load(K_FIPS);
    wait_done(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL reset_mid_reload_latency: got %0d want 10", cyc); end
    read_rk(4'd10, v);
    vectors++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin miscompares++; $display("FAIL reset_mid_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
  endtask

  task automatic test_out_of_range();
    logic [127:0] v;
    for (int i = 11; i <= 15; i++) begin
      read_rk(4'(i), v);
      vectors++; if (v !== 128'h0) begin miscompares++; $display("FAIL oor_idx%0d: got %h want 0", i, v); end
    end
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL oor_kv: got %b want 1", keys_valid); end
  endtask

  // Random keys, random mid-expansion restarts, random reads including out-of-range.
  task automatic test_random();
    int cyc, gap;
    logic [127:0] ka, kb, exp_v;
    logic [3:0] idx;
    for (int it = 0; it < 6; it++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      gap = $urandom_range(0, 9);
      pulse_load(ka);
      if (gap > 0) begin
        for (int g = 1; g < gap; g++) tick();
        pulse_load(kb);
      end else kb = ka;
      wait_done(cyc);
      vectors++; if (cyc != 10) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want 10", it, cyc); end
      ref_expand(kb);
      for (int n = 0; n < 16; n++) begin
        idx = 4'($urandom_range(0, 15));
        rd_idx = idx;
        tick();
        exp_v = (idx <= 4'd10) ? ref_rk[idx] : 128'h0;
        vectors++; if (rd_key !== exp_v) begin miscompares++; $display("FAIL rand%0d_rd%0d: got %h want %h", it, idx, rd_key, exp_v); end
      end
    end
  endtask

  // Decrypt order stream: a new index every cycle, each result one cycle later.
  task automatic test_back_to_back();
    logic [127:0] k;
    int cyc;
    k = {$urandom, $urandom, $urandom, $urandom};
    pulse_load(k);
    wait_done(cyc);
    vectors++; if (cyc != 10) begin miscompares++; $display("FAIL b2b_latency: got %0d want 10", cyc); end
    ref_expand(k);
    for (int r = 10; r >= 0; r--) begin
      rd_idx = 4'(r);
      tick();
      vectors++; if (rd_key !== ref_rk[r]) begin miscompares++; $display("FAIL b2b_rk%0d: got %h want %h", r, rd_key, ref_rk[r]); end
    end
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; rd_idx = 4'd0;
    build_sbox();
    test_reset();
    test_fips_load();
    test_second_key();
    test_restart();
    test_reset_mid();
    test_out_of_range();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes128_key_store.md
Name: aes128_key_store

Overview:
- Sequential AES-128 key-schedule unit that sits directly upstream of the AES-128 decryption datapath. It replaces per-block combinational key expansion.
- It expands a loaded cipher key iteratively, one round key per clock, and stores all 11 round keys (rk0..rk10) in a register bank.
- The decryptor reads round keys by index, in any order; normal decrypt order is rk10 first, rk0 last.
- After one load, any number of blocks decrypt with no further key-schedule work.

Parameters:
- NR, 10, number of expansion rounds; only 10 (AES-128) is supported, and other values are an elaboration error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key (rk0); byte 0 at bits [127:120]; sampled only when key_load=1.
- key_load  input  1  single-cycle request to start a new expansion.
- busy  output  1  1 while expansion is in progress.
- keys_valid  output  1  1 when all 11 round keys are stored and consistent with the last key loaded.
- done  output  1  one-cycle pulse on the cycle keys_valid first rises.
- rd_idx  input  4  round-key index to read, 0..10.
- rd_key  output  128  registered round key for rd_idx.

Behaviour:
- Reset value of every output is 0 (busy, keys_valid, done, rd_key). Reset also clears the round counter and rcon register, and sets the FSM to IDLE. Key bank contents need not be cleared.
- FSM states are IDLE, EXPAND and READY.
- IDLE to EXPAND on key_load=1. On that edge:
  - slot[0] <= key_in;
  - cnt <= 1;
  - rcon <= 8'h01;
  - busy <= 1;
  - keys_valid <= 0.
- In EXPAND, each edge writes slot[cnt] <= step(slot[cnt-1], rcon). step is standard AES-128 expansion:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0};
  - w5 = w1 ^ w4;
  - w6 = w2 ^ w5;
  - w7 = w3 ^ w6.
- The rcon register updates as xtime: rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00). The sequence is 01,02,04,08,10,20,40,80,1b,36.
- The edge that writes slot[10] moves the FSM to READY and sets busy=0, keys_valid=1 and done=1. done clears on the next edge.
- Latency: key_load sampled at edge E0 gives keys_valid=1 and done=1 after edge E10, i.e. 10 cycles later.
- READY to EXPAND on key_load=1, with the same actions as from IDLE. keys_valid drops on that edge.
- key_load=1 while in EXPAND: the expansion restarts from the new key_in, and the partial expansion is abandoned. No done pulse is generated for the abandoned key.
- rst=1 takes priority over key_load on the same edge.
- rst mid-expansion returns the FSM to IDLE with keys_valid=0. A later key_load starts a fresh expansion.
- Read port:
  - Every edge, rd_key <= slot[rd_idx] when rd_idx <= 10, else rd_key <= 0.
  - One-cycle read latency, independent of FSM state.
  - rd_key is only meaningful while keys_valid=1; during EXPAND it returns whatever the slot holds (stale or partial).
- A read of rd_idx=10 on the edge that writes slot[10] returns the old contents. Write-before-read bypass is not required.
- key_load held high for multiple cycles restarts the expansion every cycle. Upstream must pulse key_load for one cycle.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry S-box constant;
  - an xtime function;
  - a 128-bit round-key typedef;
  - RK_COUNT=11;
  - RCON_INIT=8'h01.
- One combinational sub-module, aes_key_step, performs the single-round transform (RotWord, 4x S-box, rcon XOR, word XOR chain).
- The FSM, counter, rcon register, key bank and read register live in aes128_key_store.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> busy=0, keys_valid=0, done=0, rd_key=0. Next, rd_idx=3 with no load -> rd_key=0 is not required; only keys_valid=0 is checked.
- FIPS-197 load: key_in=2b7e151628aed2a6abf7158809cf4f3c, key_load pulsed at E0:
  - keys_valid=1 and done=1 after E10, and done=0 after E11;
  - rd_idx=1 -> a0fafe1788542cb123a339392a6c7605;
  - rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rd_idx=0 -> key_in.
- Second key from READY: key_in=000102030405060708090a0b0c0d0e0f:
  - keys_valid drops the edge after load and rises 10 cycles later;
  - rd_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Restart mid-expansion: load 2b7e... and at E4 load 000102...0f:
  - exactly one done pulse, at E14;
  - rd_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Reset mid-expansion: rst at E5 -> busy=0 and keys_valid=0 next cycle, with no done pulse. Reload 2b7e... -> correct rk10 after 10 cycles.
- Out-of-range read: with keys_valid=1, rd_idx=11..15 -> rd_key=0 one cycle later.
